// File: rtl/sc_level_sequencer.sv
// Level controller for the vehicle lanes: per-level lane pattern and shift-rate divisor,
// edge-triggered start/stop, in-game level-up reload, internal lane-shift tick.
//
// state | meaning
// IDLE  | after reset, wait for the start button to be released
// ARM   | wait for a start edge, then latch the requested level
// LOAD  | one cycle: strobe the level's pattern into the lane registers
// RUN   | lanes shifting; tick every div cycles; stop or level-up leave
module sc_level_sequencer #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int NUM_LEVELS    = 4,
  parameter int LEVEL_W       = 2,
  parameter int DIV_W         = 24,
  parameter logic [NUM_LEVELS*DATAWIDTH_BUS-1:0] LEVEL_PATTERNS = {8'h81, 8'h99, 8'hA5, 8'hDB},
  parameter logic [NUM_LEVELS*DIV_W-1:0] LEVEL_DIVS =
    {24'd1250000, 24'd2500000, 24'd5000000, 24'd10000000},
  parameter bit WRAP_LEVELS = 1'b0
) (
  input  logic                     SC_LEVELSEQ_CLOCK_50,
  input  logic                     SC_LEVELSEQ_RESET_InLow,
  input  logic [LEVEL_W-1:0]       SC_LEVELSEQ_NVL_IN,
  input  logic                     SC_LEVELSEQ_CN_IN,
  input  logic                     SC_LEVELSEQ_LVLUP_IN,
  output logic                     SC_LEVELSEQ_LOAD_OUT,
  output logic [DATAWIDTH_BUS-1:0] SC_LEVELSEQ_PATTERN_OUT,
  output logic                     SC_LEVELSEQ_TICK_OUT,
  output logic [LEVEL_W-1:0]       SC_LEVELSEQ_LEVEL_OUT,
  output logic                     SC_LEVELSEQ_RUN_OUT
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, LOAD = 2'd2, RUN = 2'd3} state_t;

  localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LEVEL_W:0]   LEVEL_COUNT = (LEVEL_W + 1)'(NUM_LEVELS);

  state_t state, state_nxt;
  logic cn_q, cn_rise, term_hit;
  logic [LEVEL_W-1:0] level, level_nxt, level_up, nvl_sat;
  logic [DIV_W-1:0] cnt, cnt_nxt, div_sel, term;
  logic [DATAWIDTH_BUS-1:0] pat_sel;

  assign cn_rise = SC_LEVELSEQ_CN_IN & ~cn_q;
  assign nvl_sat = ({1'b0, SC_LEVELSEQ_NVL_IN} >= LEVEL_COUNT) ? LAST_LEVEL : SC_LEVELSEQ_NVL_IN;
  assign level_up = (level == LAST_LEVEL) ? (WRAP_LEVELS ? '0 : LAST_LEVEL)
                                          : level + LEVEL_W'(1);

  always_comb begin
    pat_sel = '0;
    div_sel = '0;
    for (int k = 0; k < NUM_LEVELS; k++) begin
      if (level == LEVEL_W'(k)) begin
        pat_sel = LEVEL_PATTERNS[k*DATAWIDTH_BUS +: DATAWIDTH_BUS];
        div_sel = LEVEL_DIVS[k*DIV_W +: DIV_W];
      end
    end
  end

  // A zero divisor behaves as one: terminal count 0, so every RUN cycle ticks.
  assign term     = (div_sel == '0) ? '0 : div_sel - DIV_W'(1);
  assign term_hit = (cnt == term);

  always_ff @(posedge SC_LEVELSEQ_CLOCK_50 or negedge SC_LEVELSEQ_RESET_InLow) begin
    if (!SC_LEVELSEQ_RESET_InLow) begin
      state <= IDLE;
      level <= '0;
      cnt   <= '0;
      cn_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      cnt   <= cnt_nxt;
      cn_q  <= SC_LEVELSEQ_CN_IN;
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (!SC_LEVELSEQ_CN_IN) state_nxt = ARM;
      ARM: begin
        if (cn_rise) begin
          level_nxt = nvl_sat;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
      RUN: begin
        if (cn_rise) begin
          cnt_nxt   = '0;
          state_nxt = ARM;
        end else if (SC_LEVELSEQ_LVLUP_IN) begin
          level_nxt = level_up;
          cnt_nxt   = '0;
          state_nxt = LOAD;
        end else begin
          cnt_nxt = term_hit ? '0 : cnt + DIV_W'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Pure state/counter decode; inputs never reach the outputs combinationally.
  assign SC_LEVELSEQ_LOAD_OUT    = (state == LOAD);
  assign SC_LEVELSEQ_PATTERN_OUT = (state == LOAD) ? pat_sel : '0;
  assign SC_LEVELSEQ_RUN_OUT     = (state == RUN);
  assign SC_LEVELSEQ_TICK_OUT    = (state == RUN) && term_hit;
  assign SC_LEVELSEQ_LEVEL_OUT   = level;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Bench for sc_level_sequencer: three parameterisations, directed stimulus pushes expected
// load/tick events into per-instance queues; a negedge monitor pops and compares them.
module tb_sc_level_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] rst_n, cn, lvlup, load, tick, run;
  logic [1:0] nvl [3];
  logic [1:0] lvl [3];
  logic [7:0] pat [3];

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         is_load;
    bit         is_tick;
    logic [7:0] pat;
    logic [1:0] lvl;
    int         cyc;
  } ev_t;

  ev_t exp_q [3][$];
  ev_t mon_e;

  // u0: four levels, divisors L0..L3 = 1,2,3,0, saturating
  sc_level_sequencer #(
    .NUM_LEVELS(4), .LEVEL_W(2),
    .LEVEL_DIVS({24'd0, 24'd3, 24'd2, 24'd1}), .WRAP_LEVELS(1'b0)
  ) u0 (
    .SC_LEVELSEQ_CLOCK_50(clk), .SC_LEVELSEQ_RESET_InLow(rst_n[0]),
    .SC_LEVELSEQ_NVL_IN(nvl[0]), .SC_LEVELSEQ_CN_IN(cn[0]), .SC_LEVELSEQ_LVLUP_IN(lvlup[0]),
    .SC_LEVELSEQ_LOAD_OUT(load[0]), .SC_LEVELSEQ_PATTERN_OUT(pat[0]),
    .SC_LEVELSEQ_TICK_OUT(tick[0]), .SC_LEVELSEQ_LEVEL_OUT(lvl[0]), .SC_LEVELSEQ_RUN_OUT(run[0])
  );

  // u1: three levels in a 2-bit index, patterns L0..L2 = DB,A5,3C, divisors 1,2,3
  sc_level_sequencer #(
    .NUM_LEVELS(3), .LEVEL_W(2),
    .LEVEL_PATTERNS({8'h3C, 8'hA5, 8'hDB}),
    .LEVEL_DIVS({24'd3, 24'd2, 24'd1}), .WRAP_LEVELS(1'b0)
  ) u1 (
    .SC_LEVELSEQ_CLOCK_50(clk), .SC_LEVELSEQ_RESET_InLow(rst_n[1]),
    .SC_LEVELSEQ_NVL_IN(nvl[1]), .SC_LEVELSEQ_CN_IN(cn[1]), .SC_LEVELSEQ_LVLUP_IN(lvlup[1]),
    .SC_LEVELSEQ_LOAD_OUT(load[1]), .SC_LEVELSEQ_PATTERN_OUT(pat[1]),
    .SC_LEVELSEQ_TICK_OUT(tick[1]), .SC_LEVELSEQ_LEVEL_OUT(lvl[1]), .SC_LEVELSEQ_RUN_OUT(run[1])
  );

  // u2: four levels, all divisors 2, wrapping
  sc_level_sequencer #(
    .NUM_LEVELS(4), .LEVEL_W(2),
    .LEVEL_DIVS({24'd2, 24'd2, 24'd2, 24'd2}), .WRAP_LEVELS(1'b1)
  ) u2 (
    .SC_LEVELSEQ_CLOCK_50(clk), .SC_LEVELSEQ_RESET_InLow(rst_n[2]),
    .SC_LEVELSEQ_NVL_IN(nvl[2]), .SC_LEVELSEQ_CN_IN(cn[2]), .SC_LEVELSEQ_LVLUP_IN(lvlup[2]),
    .SC_LEVELSEQ_LOAD_OUT(load[2]), .SC_LEVELSEQ_PATTERN_OUT(pat[2]),
    .SC_LEVELSEQ_TICK_OUT(tick[2]), .SC_LEVELSEQ_LEVEL_OUT(lvl[2]), .SC_LEVELSEQ_RUN_OUT(run[2])
  );

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (load[d] === 1'b1 || tick[d] === 1'b1) begin
        checks++;
        if (exp_q[d].size() == 0) begin
          failures++;
          $display("FAIL unexpected_event dut=%0d cyc=%0d load=%b tick=%b pat=%h lvl=%0d",
                   d, cyc, load[d], tick[d], pat[d], lvl[d]);
        end else begin
          mon_e = exp_q[d].pop_front();
          if (load[d] !== mon_e.is_load || tick[d] !== mon_e.is_tick || pat[d] !== mon_e.pat ||
              lvl[d] !== mon_e.lvl || cyc != mon_e.cyc)
          begin
            failures++;
            $display("FAIL event dut=%0d got cyc=%0d load=%b tick=%b pat=%h lvl=%0d exp cyc=%0d load=%b tick=%b pat=%h lvl=%0d",
                     d, cyc, load[d], tick[d], pat[d], lvl[d],
                     mon_e.cyc, mon_e.is_load, mon_e.is_tick, mon_e.pat, mon_e.lvl);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic push_load(input int d, input logic [7:0] p, input logic [1:0] l, input int c);
    ev_t e;
    e.is_load = 1'b1; e.is_tick = 1'b0; e.pat = p; e.lvl = l; e.cyc = c;
    exp_q[d].push_back(e);
  endtask

  task automatic push_ticks(input int d, input logic [1:0] l, input int first, input int period,
                            input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      e.is_load = 1'b0; e.is_tick = 1'b1; e.pat = 8'h00; e.lvl = l; e.cyc = first + i*period;
      exp_q[d].push_back(e);
    end
  endtask

  // Start edge from ARM; returns at the LOAD cycle with the button released.
  task automatic start(input int d, input logic [1:0] nv, input logic [7:0] p,
                       input logic [1:0] l, output int load_cyc);
    nvl[d] = nv;
    cn[d]  = 1'b1;
    push_load(d, p, l, cyc + 1);
    step(1);
    cn[d] = 1'b0;
    load_cyc = cyc;
  endtask

  task automatic chk_all_zero(input int d);
    chk("rst_load",  32'(load[d]), 32'h0);
    chk("rst_run",   32'(run[d]),  32'h0);
    chk("rst_tick",  32'(tick[d]), 32'h0);
    chk("rst_pat",   32'(pat[d]),  32'h0);
    chk("rst_level", 32'(lvl[d]),  32'h0);
  endtask

  initial begin
    int lc;
    rst_n = 3'b000;
    cn    = 3'b001;
    lvlup = 3'b000;
    for (int d = 0; d < 3; d++) nvl[d] = 2'd0;

    step(1);
    chk_all_zero(0);
    rst_n = 3'b111;

    // Button held through reset must not start the game.
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle_hold_run",  32'(run[0]),  32'h0);
      chk("idle_hold_load", 32'(load[0]), 32'h0);
    end
    cn[0] = 1'b0;
    step(2);

    // u0 level 1: A5, tick every 2nd RUN cycle, then stop.
    start(0, 2'd1, 8'hA5, 2'd1, lc);
    push_ticks(0, 2'd1, lc + 2, 2, 3);
    step(7);
    chk("run_active", 32'(run[0]), 32'h1);
    cn[0] = 1'b1;
    step(1);
    chk("stop_run",   32'(run[0]),  32'h0);
    chk("stop_tick",  32'(tick[0]), 32'h0);
    chk("stop_load",  32'(load[0]), 32'h0);
    chk("stop_level", 32'(lvl[0]),  32'h1);
    cn[0] = 1'b0;
    step(1);

    // u0 level 2 (div 3), level-up to 3 (pattern 81, div 0 -> every cycle), reset mid-RUN.
    start(0, 2'd2, 8'h99, 2'd2, lc);
    push_ticks(0, 2'd2, lc + 3, 3, 2);
    step(7);
    chk("l2_level", 32'(lvl[0]), 32'h2);
    lvlup[0] = 1'b1;
    push_load(0, 8'h81, 2'd3, cyc + 1);
    step(1);
    lvlup[0] = 1'b0;
    push_ticks(0, 2'd3, lc + 9, 1, 4);
    step(5);
    chk("div0_run", 32'(run[0]), 32'h1);
    rst_n[0] = 1'b0;
    #1;
    chk_all_zero(0);
    step(1);
    rst_n[0] = 1'b1;

    // u1: NVL 3 saturates to level 2; saturated level-up reloads; stop beats level-up.
    start(1, 2'd3, 8'h3C, 2'd2, lc);
    push_ticks(1, 2'd2, lc + 3, 3, 2);
    step(7);
    lvlup[1] = 1'b1;
    push_load(1, 8'h3C, 2'd2, cyc + 1);
    step(1);
    lvlup[1] = 1'b0;
    chk("sat_level", 32'(lvl[1]), 32'h2);
    push_ticks(1, 2'd2, lc + 11, 3, 2);
    step(8);
    cn[1]    = 1'b1;
    lvlup[1] = 1'b1;
    step(1);
    lvlup[1] = 1'b0;
    chk("both_run",   32'(run[1]),  32'h0);
    chk("both_load",  32'(load[1]), 32'h0);
    chk("both_tick",  32'(tick[1]), 32'h0);
    chk("both_level", 32'(lvl[1]),  32'h2);
    cn[1] = 1'b0;
    step(1);
    start(1, 2'd0, 8'hDB, 2'd0, lc);
    push_ticks(1, 2'd0, lc + 1, 1, 3);
    step(4);
    rst_n[1] = 1'b0;
    #1;
    chk_all_zero(1);
    step(1);
    rst_n[1] = 1'b1;

    // u2: level-up ignored in ARM; wrap from level 3 to 0.
    lvlup[2] = 1'b1;
    step(1);
    lvlup[2] = 1'b0;
    chk("arm_lvlup_ignored", 32'(lvl[2]), 32'h0);
    start(2, 2'd3, 8'h81, 2'd3, lc);
    push_ticks(2, 2'd3, lc + 2, 2, 2);
    step(5);
    lvlup[2] = 1'b1;
    push_load(2, 8'hDB, 2'd0, cyc + 1);
    step(1);
    lvlup[2] = 1'b0;
    push_ticks(2, 2'd0, lc + 8, 2, 2);
    step(5);
    cn[2] = 1'b1;
    step(1);
    chk("wrap_stop_run",   32'(run[2]), 32'h0);
    chk("wrap_stop_level", 32'(lvl[2]), 32'h0);
    cn[2] = 1'b0;

    step(3);
    for (int d = 0; d < 3; d++) chk("events_pending", 32'(exp_q[d].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
